// File: rtl/cache_module_if.sv
// Command/result bundle between the L2 controller and the tag/state/LRU core.
// The master drives one command per cycle; the slave returns registered results.
// There is no backpressure: op_valid is always accepted.
interface cache_module_if #(
  parameter int TAG_W   = 12,
  parameter int INDEX_W = 4
);
  logic               op_valid;
  logic [2:0]         op;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         way;
  logic [3:0]         cmd;
  logic [1:0]         snoop_res;
  logic               done;
  logic               hit;
  logic [2:0]         result_way;
  logic [1:0]         mesi_out;

  modport master (
    output op_valid, op, index, tag, way, cmd, snoop_res,
    input  done, hit, result_way, mesi_out
  );

  modport slave (
    input  op_valid, op, index, tag, way, cmd, snoop_res,
    output done, hit, result_way, mesi_out
  );
endinterface

// File: rtl/cache_module.sv
// Tag, MESI and true-LRU age storage for an 8-way set-associative L2 cache.
// Latency: one cycle; results are registered and held until the next non-NOP op.
// Backpressure: none; one command is accepted every cycle.
module cache_module #(
  parameter int TAG_W   = 12,
  parameter int INDEX_W = 4,
  parameter int WAYS    = 8
) (
  input  logic           clk,
  input  logic           rst,
  cache_module_if.slave  bus
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_WRITE_TAG = 3'd1,
    OP_TOUCH     = 3'd2,
    OP_UPDATE    = 3'd3,
    OP_LOOKUP    = 3'd4,
    OP_EVICT     = 3'd5,
    OP_CLEAR     = 3'd6,
    OP_NOP7      = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  // Per-set line state; age 0 is most recently used, age 7 is the LRU way.
  logic [TAG_W-1:0] r_tag  [SETS][WAYS];
  mesi_e            r_mesi [SETS][WAYS];
  logic [2:0]       r_age  [SETS][WAYS];

  logic  r_done;
  logic  r_hit;
  logic  [2:0] r_result_way;
  mesi_e r_mesi_out;

  op_e   w_op;
  logic  w_exec;
  logic  w_hit;
  logic  [2:0] w_hit_way;
  logic  w_inv_found;
  logic  [2:0] w_inv_way;
  logic  [2:0] w_lru_way;
  logic  [2:0] w_victim;
  mesi_e w_cur_mesi;
  mesi_e w_next_mesi;

  assign w_op       = op_e'(bus.op);
  assign w_exec     = bus.op_valid && (w_op != OP_NOP) && (w_op != OP_NOP7);
  assign w_cur_mesi = r_mesi[bus.index][bus.way];
  assign w_victim   = w_inv_found ? w_inv_way : w_lru_way;

  // Tag match: scan downwards so the lowest matching valid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 3'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[bus.index][w] != MESI_I && r_tag[bus.index][w] == bus.tag) begin
        w_hit     = 1'b1;
        w_hit_way = 3'(w);
      end
    end
  end

  // Victim candidates: lowest invalid way, and the way currently holding age 7.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = 3'd0;
    w_lru_way   = 3'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[bus.index][w] == MESI_I) begin
        w_inv_found = 1'b1;
        w_inv_way   = 3'(w);
      end
      if (r_age[bus.index][w] == 3'd7) begin
        w_lru_way = 3'(w);
      end
    end
  end

  // MESI transition for the addressed line; snoop_res 3 behaves like NOHIT.
  always_comb begin
    w_next_mesi = w_cur_mesi;
    case (bus.cmd)
      4'd0, 4'd2: begin
        if (w_cur_mesi == MESI_I) begin
          w_next_mesi = (bus.snoop_res == 2'd1 || bus.snoop_res == 2'd2) ? MESI_S : MESI_E;
        end
      end
      4'd1: w_next_mesi = MESI_M;
      4'd3: begin
        if (w_cur_mesi == MESI_S) w_next_mesi = MESI_I;
      end
      4'd4: begin
        if (w_cur_mesi == MESI_M || w_cur_mesi == MESI_E) w_next_mesi = MESI_S;
      end
      4'd6: w_next_mesi = MESI_I;
      default: w_next_mesi = w_cur_mesi;
    endcase
  end

  // Array state: reset and CLEAR restore tags 0, lines invalid, age[w] = w.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]  <= '0;
          r_mesi[s][w] <= MESI_I;
          r_age[s][w]  <= 3'(w);
        end
      end
    end else if (bus.op_valid) begin
      case (w_op)
        OP_WRITE_TAG: r_tag[bus.index][bus.way] <= bus.tag;
        OP_TOUCH: begin
          for (int v = 0; v < WAYS; v++) begin
            if (r_age[bus.index][v] < r_age[bus.index][bus.way]) begin
              r_age[bus.index][v] <= r_age[bus.index][v] + 3'd1;
            end
          end
          r_age[bus.index][bus.way] <= 3'd0;
        end
        OP_UPDATE: r_mesi[bus.index][bus.way] <= w_next_mesi;
        OP_CLEAR: begin
          for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
              r_tag[s][w]  <= '0;
              r_mesi[s][w] <= MESI_I;
              r_age[s][w]  <= 3'(w);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: done pulses for one cycle, the rest hold across NOPs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_hit        <= 1'b0;
      r_result_way <= 3'd0;
      r_mesi_out   <= MESI_I;
    end else begin
      r_done <= w_exec;
      if (w_exec) begin
        case (w_op)
          OP_WRITE_TAG, OP_TOUCH: begin
            r_hit        <= 1'b0;
            r_result_way <= bus.way;
            r_mesi_out   <= w_cur_mesi;
          end
          OP_UPDATE: begin
            r_hit        <= 1'b0;
            r_result_way <= bus.way;
            r_mesi_out   <= w_next_mesi;
          end
          OP_LOOKUP: begin
            r_hit        <= w_hit;
            r_result_way <= w_hit_way;
            r_mesi_out   <= w_hit ? r_mesi[bus.index][w_hit_way] : MESI_I;
          end
          OP_EVICT: begin
            r_hit        <= 1'b0;
            r_result_way <= w_victim;
            r_mesi_out   <= r_mesi[bus.index][w_victim];
          end
          default: begin
            r_hit        <= 1'b0;
            r_result_way <= 3'd0;
            r_mesi_out   <= MESI_I;
          end
        endcase
      end
    end
  end

  assign bus.done       = r_done;
  assign bus.hit        = r_hit;
  assign bus.result_way = r_result_way;
  assign bus.mesi_out   = r_mesi_out;

endmodule

// File: tb/tb_cache_module.sv
// Directed plus randomized bench for cache_module against a recency-list model.
module tb_cache_module;

  logic clk;
  logic rst;

  cache_module_if #(.TAG_W(12), .INDEX_W(4)) bus ();

  cache_module #(.TAG_W(12), .INDEX_W(4), .WAYS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model: tags, MESI (0 I, 1 S, 2 E, 3 M) and a recency list per set
  // (m_order[s][0] is the most recently used way, m_order[s][7] the LRU way).
  int m_tag   [16][8];
  int m_mesi  [16][8];
  int m_order [16][8];

  // Last values the outputs must be holding, and whether they are defined.
  int last_hit, last_rw, last_mesi;
  bit hit_known, rw_known, mesi_known;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 8; w++) begin
        m_tag[s][w]   = 0;
        m_mesi[s][w]  = 0;
        m_order[s][w] = w;
      end
    end
  endfunction

  function automatic int next_mesi(input int cur, input int cm, input int sr);
    case (cm)
      0, 2:    return (cur == 0) ? ((sr == 1 || sr == 2) ? 1 : 2) : cur;
      1:       return 3;
      3:       return (cur == 1) ? 0 : cur;
      4:       return (cur >= 2) ? 1 : cur;
      6:       return 0;
      default: return cur;
    endcase
  endfunction

  function automatic int victim(input int s);
    for (int w = 0; w < 8; w++) if (m_mesi[s][w] == 0) return w;
    return m_order[s][7];
  endfunction

  task automatic issue(input int op, input int idx, input int tg, input int wy,
                       input int cm, input int sr);
    int e_hit, e_rw, e_mesi, nm, p;
    @(negedge clk);
    bus.op_valid  = 1'b1;
    bus.op        = 3'(op);
    bus.index     = 4'(idx);
    bus.tag       = 12'(tg);
    bus.way       = 3'(wy);
    bus.cmd       = 4'(cm);
    bus.snoop_res = 2'(sr);
    // Expected results from the pre-op model state.
    e_hit = 0; e_rw = 0; e_mesi = 0;
    for (int w = 7; w >= 0; w--) begin
      if (op == 4 && m_mesi[idx][w] != 0 && m_tag[idx][w] == tg) begin
        e_hit = 1; e_rw = w; e_mesi = m_mesi[idx][w];
      end
    end
    nm = next_mesi(m_mesi[idx][wy], cm, sr);
    @(posedge clk);
    #1;
    chk("done", 32'(bus.done), 32'((op != 0 && op != 7) ? 1 : 0));
    case (op)
      1, 2: begin
        chk("mesi_out_cur", 32'(bus.mesi_out), 32'(m_mesi[idx][wy]));
        last_mesi = m_mesi[idx][wy];
        mesi_known = 1; hit_known = 0; rw_known = 0;
      end
      3: begin
        chk("mesi_out_new", 32'(bus.mesi_out), 32'(nm));
        last_mesi = nm;
        mesi_known = 1; hit_known = 0; rw_known = 0;
      end
      4: begin
        chk("lookup_hit", 32'(bus.hit), 32'(e_hit));
        chk("lookup_way", 32'(bus.result_way), 32'(e_rw));
        chk("lookup_mesi", 32'(bus.mesi_out), 32'(e_mesi));
        last_hit = e_hit; last_rw = e_rw; last_mesi = e_mesi;
        hit_known = 1; rw_known = 1; mesi_known = 1;
      end
      5: begin
        chk("evict_way", 32'(bus.result_way), 32'(victim(idx)));
        last_rw = victim(idx);
        rw_known = 1; hit_known = 0; mesi_known = 0;
      end
      6: begin
        hit_known = 0; rw_known = 0; mesi_known = 0;
      end
      default: begin
        if (hit_known)  chk("hold_hit", 32'(bus.hit), 32'(last_hit));
        if (rw_known)   chk("hold_way", 32'(bus.result_way), 32'(last_rw));
        if (mesi_known) chk("hold_mesi", 32'(bus.mesi_out), 32'(last_mesi));
      end
    endcase
    // Apply the op to the model.
    case (op)
      1: m_tag[idx][wy] = tg;
      2: begin
        p = 0;
        for (int q = 0; q < 8; q++) if (m_order[idx][q] == wy) p = q;
        for (int q = p; q > 0; q--) m_order[idx][q] = m_order[idx][q-1];
        m_order[idx][0] = wy;
      end
      3: m_mesi[idx][wy] = nm;
      6: model_reset();
      default: ;
    endcase
    bus.op_valid = 1'b0;
  endtask

  task automatic outputs_zero(input string nm);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_hit"}, 32'(bus.hit), 32'd0);
    chk({nm, "_way"}, 32'(bus.result_way), 32'd0);
    chk({nm, "_mesi"}, 32'(bus.mesi_out), 32'd0);
  endtask

  initial begin
    int rop;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = '0; bus.index = '0; bus.tag = '0;
    bus.way = '0; bus.cmd = '0; bus.snoop_res = '0;
    model_reset();
    hit_known = 1; rw_known = 1; mesi_known = 1;
    last_hit = 0; last_rw = 0; last_mesi = 0;
    repeat (2) @(posedge clk);
    #1;
    outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill set 0 with tags 0..7, each touched and read exclusive.
    for (int w = 0; w < 8; w++) begin
      issue(1, 0, w, w, 0, 0);
      issue(2, 0, 0, w, 0, 0);
      issue(3, 0, 0, w, 0, 0);
    end
    issue(5, 0, 0, 0, 0, 0);
    // Replace way 0, LRU moves to way 1; evict is read-only.
    issue(1, 0, 8, 0, 0, 0);
    issue(2, 0, 0, 0, 0, 0);
    issue(3, 0, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0, 0);
    // Lookups, then a NOP that must hold the lookup result.
    issue(4, 0, 8, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0);
    issue(7, 0, 0, 0, 0, 0);
    issue(4, 0, 0, 0, 0, 0);
    // MESI walk on set 1 way 2.
    issue(3, 1, 0, 2, 0, 1);
    issue(3, 1, 0, 2, 3, 0);
    issue(3, 1, 0, 2, 0, 0);
    issue(3, 1, 0, 2, 4, 0);
    issue(3, 1, 0, 2, 1, 0);
    issue(3, 1, 0, 2, 4, 0);
    issue(3, 1, 0, 2, 6, 0);
    // Invalid-way victim selection in set 2.
    issue(5, 2, 0, 0, 0, 0);
    for (int w = 0; w < 3; w++) issue(3, 2, 0, w, 1, 0);
    issue(5, 2, 0, 0, 0, 0);

    // Reset arrives while a lookup is pending: no done pulse.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 3'd4; bus.index = 4'd0; bus.tag = 12'd8;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    outputs_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    model_reset();
    hit_known = 1; rw_known = 1; mesi_known = 1;
    last_hit = 0; last_rw = 0; last_mesi = 0;
    issue(5, 0, 0, 0, 0, 0);
    // All ways valid without touches: age 7 still belongs to way 7.
    for (int w = 0; w < 8; w++) issue(3, 3, 0, w, 1, 0);
    issue(5, 3, 0, 0, 0, 0);
    issue(4, 0, 8, 0, 0, 0);
    // CLEAR wipes set 3 back to invalid.
    issue(6, 0, 0, 0, 0, 0);
    issue(5, 3, 0, 0, 0, 0);

    // Randomized traffic over a few sets and a small tag space.
    for (int n = 0; n < 600; n++) begin
      rop = $urandom_range(0, 7);
      if (rop == 6 && $urandom_range(0, 15) != 0) rop = 4;
      issue(rop, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 15), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_module.md
Name: cache_module

Overview:
- Tag/state/replacement core of an 8-way set-associative L2 cache.
- Per set it holds eight tags, eight MESI states and true-LRU age counters.
- Accepts one command per cycle: tag write, LRU touch, MESI update, lookup, victim selection, clear. Returns results one cycle later.
- Sits under the L2 controller, which sequences trace commands into these primitive operations.

Parameters:
- TAG_W, 12, tag width in bits.
- INDEX_W, 4, set-index width; the number of sets is 2**INDEX_W.
- WAYS, 8, associativity. Fixed at 8; way and age fields are 3 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  command strobe. Always accepted; there is no ready signal.
- op  input  3  0 NOP, 1 WRITE_TAG, 2 TOUCH, 3 UPDATE_MESI, 4 LOOKUP, 5 FIND_EVICT, 6 CLEAR.
- index  input  INDEX_W  target set.
- tag  input  TAG_W  tag for WRITE_TAG and LOOKUP.
- way  input  3  target way for WRITE_TAG, TOUCH and UPDATE_MESI.
- cmd  input  4  trace command for UPDATE_MESI: 0 read, 1 write, 2 instr read, 3 snoop inval, 4 snoop read, 5 snoop write, 6 snoop RWIM.
- snoop_res  input  2  0 NOHIT, 1 HIT, 2 HITM, 3 treated as NOHIT.
- done  output  1  one-cycle pulse, one cycle after any accepted op other than NOP.
- hit  output  1  LOOKUP result.
- result_way  output  3  hit way (LOOKUP) or victim way (FIND_EVICT).
- mesi_out  output  2  state of the addressed line after the op. Encoding: I=0, S=1, E=2, M=3.

Behaviour:
- Reset, asynchronous:
  - All tags 0 and all MESI states I in every set.
  - age[w] = w for every set.
  - done, hit, result_way and mesi_out all 0.
- Reset asserted mid-operation drops the pending result; done stays 0.
- Latency: exactly 1 cycle. Outputs are registered and hold their value until the next non-NOP op.
- WRITE_TAG: tag[index][way] <= tag. MESI and ages are unchanged. mesi_out = current state of that line.
- TOUCH (true LRU):
  - Every way v with age[v] < age[way] gets age[v]+1.
  - age[way] <= 0.
  - Ages within a set always remain a permutation of 0..7.
- UPDATE_MESI, next state from cmd:
  - cmd 0 or 2:
    - I becomes E if snoop_res is NOHIT (or 3), otherwise S.
    - S, E and M hold.
  - cmd 1: line becomes M.
  - cmd 3: S becomes I; other states hold.
  - cmd 4: M and E become S; S and I hold.
  - cmd 5: no change.
  - cmd 6: line becomes I.
  - cmd 7..15: no change.
  - mesi_out = the new state.
- LOOKUP:
  - hit = 1 if some way has MESI != I and a matching tag.
  - result_way = lowest such way; 0 on miss.
  - mesi_out = state of the hit way; I on miss.
  - No state change.
- FIND_EVICT:
  - If any way in the set is I, result_way = lowest-numbered invalid way.
  - Otherwise result_way = the way with age 7 (least recently used).
  - Purely read-only: no tag, MESI or age change.
- CLEAR: same state as reset, applied synchronously to all sets. done pulses.
- Ops 0 and 7 are NOPs: no state change, no done pulse.
- One op per cycle. Results reflect state before the current edge's update of the same op, except TOUCH/UPDATE_MESI, whose mesi_out shows the new state.

Test Plan:
- Fill set 0: for w=0..7, WRITE_TAG(tag=w, way=w), TOUCH(w), UPDATE_MESI(cmd=0, snoop_res=NOHIT). Then FIND_EVICT(index 0) -> result_way=0. Every line is E.
- Continue: WRITE_TAG(tag=8, way=0), TOUCH(0), UPDATE_MESI(cmd 0, NOHIT), FIND_EVICT -> result_way=1. A second FIND_EVICT -> 1 again (read-only).
- After reset, FIND_EVICT(any set) -> 0. Set ways 0..2 valid via UPDATE_MESI(cmd 1) -> FIND_EVICT=3, mesi_out=M on those updates.
- LOOKUP(tag=8, set 0) -> hit=1, result_way=0, mesi_out=E. LOOKUP(tag=0) -> hit=0.
- MESI walk on one line: read+HIT -> S; snoop inval -> I; read+NOHIT -> E; snoop read -> S; write -> M; snoop read -> S; RWIM -> I.
- Assert rst mid-stream, or issue CLEAR -> all lines I, FIND_EVICT=0, done low during reset, ages restored.
